// File: rtl/timer_0_host_ctrl.sv
// Purpose: Avalon-MM host that programs and services a 16-bit-data interval-timer slave.
// Latency: start accept -> control write 4 cycles; snap accept -> snap_valid 5 cycles; irq -> clear write next cycle.
// Backpressure: cmd_ready is high only in IDLE/RUN; commands that are not ready or lose arbitration are dropped.
//
// Ports:
//   clk, reset_n         single clock, synchronous active-low reset
//   cmd_*                local commands (start/stop/snap pulses plus start arguments)
//   cmd_ready, cmd_err   command acceptance status; cmd_err pulses on a start with a too-small period
//   running, tick,       timer status, timeout pulse and serviced-timeout counter
//   tick_count
//   snap_valid/value     snapshot of the timer counter
//   address..writedata   Avalon-MM host signals; readdata is registered by the slave
//   irq                  level interrupt from the timer
module timer_0_host_ctrl #(
  parameter int TICK_CNT_W = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  input  logic                  cmd_irq_en,
  input  logic                  cmd_stop,
  input  logic                  cmd_snap,
  output logic                  cmd_ready,
  output logic                  cmd_err,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic [2:0]            address,
  output logic                  chipselect,
  output logic                  write_n,
  output logic [15:0]           writedata,
  input  logic [15:0]           readdata,
  input  logic                  irq
);

  // S_STOP is a stand-alone stop command; S_STOPS is the stop write that opens a start sequence.
  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_CLR, S_STOP, S_STOPS, S_PL, S_PH, S_CTRL,
    S_SNAP_W, S_RD_L, S_CAP_L, S_RD_H, S_CAP_H
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_period_m1;
  logic                  r_cont;
  logic                  r_irq_en;
  logic                  r_running;
  logic                  w_running_nxt;
  logic [TICK_CNT_W-1:0] r_tick_cnt;
  logic [31:0]           r_snap;
  logic                  r_cmd_err;
  logic                  w_arb;
  logic                  w_bad_period;
  logic                  w_start_win;
  logic                  w_acc_start;

  assign w_arb        = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_bad_period = cmd_period < 32'(MIN_PERIOD);
  // A start only wins when nothing of higher priority is pending this cycle.
  assign w_start_win  = w_arb && !irq && !cmd_stop && !cmd_snap && cmd_start;
  assign w_acc_start  = w_start_win && !w_bad_period;

  always_comb begin
    w_next        = r_state;
    w_running_nxt = r_running;
    chipselect    = 1'b0;
    write_n       = 1'b1;
    address       = 3'd0;
    writedata     = 16'h0000;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (irq)              w_next = S_CLR;
        else if (cmd_stop)    w_next = S_STOP;
        else if (cmd_snap)    w_next = S_SNAP_W;
        else if (w_acc_start) w_next = S_STOPS;
      end
      S_CLR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        if (!r_cont) w_running_nxt = 1'b0;
        w_next = w_running_nxt ? S_RUN : S_IDLE;
      end
      S_STOP, S_STOPS: begin
        chipselect    = 1'b1;
        write_n       = 1'b0;
        address       = 3'd1;
        writedata     = 16'h0008;
        w_running_nxt = 1'b0;
        w_next        = (r_state == S_STOPS) ? S_PL : S_IDLE;
      end
      S_PL: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd2;
        writedata  = r_period_m1[15:0];
        w_next     = S_PH;
      end
      S_PH: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd3;
        writedata  = r_period_m1[31:16];
        w_next     = S_CTRL;
      end
      S_CTRL: begin
        chipselect    = 1'b1;
        write_n       = 1'b0;
        address       = 3'd1;
        writedata     = {12'h000, 1'b0, 1'b1, r_cont, r_irq_en};
        w_running_nxt = 1'b1;
        w_next        = S_RUN;
      end
      S_SNAP_W: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd4;
        w_next     = S_RD_L;
      end
      S_RD_L: begin
        chipselect = 1'b1;
        address    = 3'd4;
        w_next     = S_CAP_L;
      end
      S_CAP_L: w_next = S_RD_H;
      S_RD_H: begin
        chipselect = 1'b1;
        address    = 3'd5;
        w_next     = S_CAP_H;
      end
      S_CAP_H: w_next = r_running ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_period_m1 <= 32'h0;
      r_cont      <= 1'b0;
      r_irq_en    <= 1'b0;
      r_running   <= 1'b0;
      r_tick_cnt  <= '0;
      r_snap      <= 32'h0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= w_running_nxt;
      r_cmd_err <= w_start_win && w_bad_period;
      if (w_acc_start) begin
        r_period_m1 <= cmd_period - 32'd1;
        r_cont      <= cmd_continuous;
        r_irq_en    <= cmd_irq_en;
        r_tick_cnt  <= '0;
      end else if (r_state == S_CLR) begin
        r_tick_cnt  <= r_tick_cnt + TICK_CNT_W'(1);
      end
      if (r_state == S_CAP_L) r_snap[15:0]  <= readdata;
      if (r_state == S_CAP_H) r_snap[31:16] <= readdata;
    end
  end

  assign cmd_ready  = w_arb;
  assign cmd_err    = r_cmd_err;
  assign running    = r_running;
  assign tick       = (r_state == S_CLR);
  assign tick_count = r_tick_cnt;
  assign snap_valid = (r_state == S_CAP_H);
  // The high half is forwarded straight from readdata so the value is complete alongside snap_valid.
  assign snap_value = (r_state == S_CAP_H) ? {readdata, r_snap[15:0]} : r_snap;

endmodule

// File: tb/tb_timer_0_host_ctrl.sv
module tb_timer_0_host_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_start = 1'b0, cmd_continuous = 1'b0, cmd_irq_en = 1'b0;
  logic        cmd_stop = 1'b0, cmd_snap = 1'b0;
  logic [31:0] cmd_period = 32'd0;
  logic        cmd_ready, cmd_err, running, tick, snap_valid, chipselect, write_n;
  logic [15:0] tick_count, writedata;
  logic [31:0] snap_value;
  logic [2:0]  address;
  logic [15:0] readdata;
  logic        irq, irq_set = 1'b0;
  logic [31:0] cnt_val = 32'h0001_2345;
  logic [31:0] snap_reg;
  int          cyc = 0;
  int          vec = 0;
  int          errs = 0;

  typedef struct {int c; bit wr; logic [2:0] a; logic [15:0] d;} bus_t;
  bus_t blog[$];

  always #5 clk = ~clk;

  timer_0_host_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en), .cmd_stop(cmd_stop),
    .cmd_snap(cmd_snap), .cmd_ready(cmd_ready), .cmd_err(cmd_err), .running(running),
    .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave model: irq drops after the status clear, snapshot on write to reg 4, registered reads.
  always @(posedge clk) begin
    if (!reset_n) begin
      irq <= 1'b0; readdata <= 16'h0; snap_reg <= 32'h0;
    end else begin
      if (chipselect && !write_n && address == 3'd0) irq <= 1'b0;
      else if (irq_set) irq <= 1'b1;
      if (chipselect && !write_n && address == 3'd4) snap_reg <= cnt_val;
      if (chipselect && write_n)
        readdata <= (address == 3'd4) ? snap_reg[15:0] : (address == 3'd5) ? snap_reg[31:16] : 16'h0;
    end
  end

  always @(negedge clk) if (chipselect === 1'b1) blog.push_back('{cyc, !write_n, address, writedata});

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (chipselect !== 1'b0) begin errs++; $display("FAIL rst_cs: got %b expected 0", chipselect); end
    vec++; if (write_n !== 1'b1) begin errs++; $display("FAIL rst_wn: got %b expected 1", write_n); end
    vec++; if ({address, writedata} !== 19'h0) begin errs++; $display("FAIL rst_bus: got %h/%h expected 0/0", address, writedata); end
    vec++; if ({running, tick, cmd_err, snap_valid} !== 4'b0) begin errs++; $display("FAIL rst_flags: got %b expected 0000", {running, tick, cmd_err, snap_valid}); end
    vec++; if (tick_count !== 16'h0 || snap_value !== 32'h0) begin errs++; $display("FAIL rst_cnt: got %h/%h expected 0/0", tick_count, snap_value); end
    reset_n = 1'b1;
    @(negedge clk);
    vec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_start();
    logic [2:0]  ea [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
    logic [15:0] ed [4] = '{16'h0008, 16'h0063, 16'h0000, 16'h0007};
    int k;
    blog.delete();
    cmd_period = 32'd100; cmd_continuous = 1'b1; cmd_irq_en = 1'b1; cmd_start = 1'b1; k = cyc;
    @(negedge clk); cmd_start = 1'b0;
    repeat (5) @(negedge clk);
    vec++;
    if (blog.size() != 4) begin errs++; $display("FAIL start_len: got %0d writes expected 4", blog.size()); end
    else for (int i = 0; i < 4; i++) begin
      vec++;
      if (blog[i].c !== k + 1 + i || !blog[i].wr || blog[i].a !== ea[i] || blog[i].d !== ed[i]) begin
        errs++; $display("FAIL start_wr%0d: got cyc %0d (%0d,%h) wr %0d expected cyc %0d (%0d,%h) wr 1",
                         i, blog[i].c - k, blog[i].a, blog[i].d, blog[i].wr, 1 + i, ea[i], ed[i]);
      end
    end
    vec++; if (running !== 1'b1) begin errs++; $display("FAIL start_running: got %b expected 1", running); end
  endtask

  task automatic test_continuous();
    int nclr = 0;
    blog.delete();
    for (int i = 0; i < 3; i++) begin
      irq_set = 1'b1; @(negedge clk); irq_set = 1'b0;
      @(negedge clk);
      vec++; if (tick !== 1'b1 || chipselect !== 1'b1 || write_n !== 1'b0 || address !== 3'd0 || writedata !== 16'h0)
        begin errs++; $display("FAIL cont_clr%0d: got tick %b cs %b wn %b a %0d d %h expected 1 1 0 0 0000", i, tick, chipselect, write_n, address, writedata); end
      @(negedge clk);
      vec++; if (tick !== 1'b0 || chipselect !== 1'b0) begin errs++; $display("FAIL cont_nodup%0d: got tick %b cs %b expected 0 0", i, tick, chipselect); end
      repeat (2) @(negedge clk);
    end
    foreach (blog[j]) if (blog[j].wr && blog[j].a == 3'd0) nclr++;
    vec++; if (nclr != 3) begin errs++; $display("FAIL cont_nclr: got %0d expected 3", nclr); end
    vec++; if (tick_count !== 16'd3) begin errs++; $display("FAIL cont_count: got %0d expected 3", tick_count); end
    vec++; if (running !== 1'b1) begin errs++; $display("FAIL cont_running: got %b expected 1", running); end
  endtask

  task automatic test_start_stop();
    int k;
    blog.delete();
    cmd_period = 32'd50; cmd_start = 1'b1; cmd_stop = 1'b1; k = cyc;
    @(negedge clk); cmd_start = 1'b0; cmd_stop = 1'b0;
    repeat (6) @(negedge clk);
    vec++;
    if (blog.size() != 1) begin errs++; $display("FAIL ss_len: got %0d writes expected 1", blog.size()); end
    else begin
      vec++; if (blog[0].c !== k + 1 || !blog[0].wr || blog[0].a !== 3'd1 || blog[0].d !== 16'h0008)
        begin errs++; $display("FAIL ss_wr: got (%0d,%h) expected (1,0008)", blog[0].a, blog[0].d); end
    end
    vec++; if (running !== 1'b0) begin errs++; $display("FAIL ss_running: got %b expected 0", running); end
    blog.delete();
    cmd_period = 32'd1; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    vec++; if (cmd_err !== 1'b1) begin errs++; $display("FAIL err_pulse: got %b expected 1", cmd_err); end
    @(negedge clk);
    vec++; if (cmd_err !== 1'b0) begin errs++; $display("FAIL err_clear: got %b expected 0", cmd_err); end
    repeat (5) @(negedge clk);
    vec++; if (blog.size() != 0) begin errs++; $display("FAIL err_nobus: got %0d bus cycles expected 0", blog.size()); end
  endtask

  task automatic test_oneshot();
    cmd_period = 32'd10; cmd_continuous = 1'b0; cmd_irq_en = 1'b1; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    repeat (5) @(negedge clk);
    vec++; if (running !== 1'b1) begin errs++; $display("FAIL os_running: got %b expected 1", running); end
    irq_set = 1'b1; @(negedge clk); irq_set = 1'b0;
    @(negedge clk);
    vec++; if (tick !== 1'b1 || address !== 3'd0 || write_n !== 1'b0) begin errs++; $display("FAIL os_clr: got tick %b a %0d wn %b expected 1 0 0", tick, address, write_n); end
    @(negedge clk);
    vec++; if (running !== 1'b0 || cmd_ready !== 1'b1 || chipselect !== 1'b0) begin errs++; $display("FAIL os_idle: got run %b rdy %b cs %b expected 0 1 0", running, cmd_ready, chipselect); end
    vec++; if (tick_count !== 16'd1) begin errs++; $display("FAIL os_count: got %0d expected 1", tick_count); end
  endtask

  task automatic test_snap();
    bit          ew [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  ea [3] = '{3'd4, 3'd4, 3'd5};
    int          ec [3] = '{1, 2, 4};
    int k;
    blog.delete();
    cmd_snap = 1'b1; k = cyc;
    @(negedge clk); cmd_snap = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (snap_valid !== 1'b0) begin errs++; $display("FAIL snap_early: got %b expected 0", snap_valid); end
    @(negedge clk);
    vec++; if (snap_valid !== 1'b1 || snap_value !== 32'h0001_2345) begin errs++; $display("FAIL snap_val: got %b %h expected 1 00012345", snap_valid, snap_value); end
    @(negedge clk);
    vec++; if (snap_valid !== 1'b0 || snap_value !== 32'h0001_2345) begin errs++; $display("FAIL snap_hold: got %b %h expected 0 00012345", snap_valid, snap_value); end
    vec++;
    if (blog.size() != 3) begin errs++; $display("FAIL snap_len: got %0d bus cycles expected 3", blog.size()); end
    else for (int i = 0; i < 3; i++) begin
      vec++; if (blog[i].c !== k + ec[i] || blog[i].wr !== ew[i] || blog[i].a !== ea[i])
        begin errs++; $display("FAIL snap_bus%0d: got cyc %0d wr %0d a %0d expected %0d %0d %0d", i, blog[i].c - k, blog[i].wr, blog[i].a, ec[i], ew[i], ea[i]); end
    end
  endtask

  task automatic test_period_bounds();
    logic [31:0] per [2] = '{32'd2, 32'h0003_0000};
    logic [15:0] epl [2] = '{16'h0001, 16'hFFFF};
    logic [15:0] eph [2] = '{16'h0000, 16'h0002};
    for (int i = 0; i < 2; i++) begin
      blog.delete();
      cmd_period = per[i]; cmd_continuous = 1'b0; cmd_irq_en = 1'b0; cmd_start = 1'b1;
      @(negedge clk); cmd_start = 1'b0;
      vec++; if (cmd_err !== 1'b0) begin errs++; $display("FAIL pb_err%0d: got %b expected 0", i, cmd_err); end
      repeat (5) @(negedge clk);
      vec++;
      if (blog.size() != 4) begin errs++; $display("FAIL pb_len%0d: got %0d expected 4", i, blog.size()); end
      else begin
        vec++; if (blog[1].d !== epl[i] || blog[2].d !== eph[i] || blog[3].d !== 16'h0004)
          begin errs++; $display("FAIL pb_data%0d: got %h %h %h expected %h %h 0004", i, blog[1].d, blog[2].d, blog[3].d, epl[i], eph[i]); end
      end
    end
    cmd_stop = 1'b1; @(negedge clk); cmd_stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int m;
    cmd_period = 32'd100; cmd_continuous = 1'b1; cmd_irq_en = 1'b1; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (address !== 3'd3 || write_n !== 1'b0) begin errs++; $display("FAIL rm_ph: got a %0d wn %b expected 3 0", address, write_n); end
    reset_n = 1'b0;
    @(negedge clk);
    vec++; if (chipselect !== 1'b0 || running !== 1'b0 || tick_count !== 16'h0) begin errs++; $display("FAIL rm_idle: got cs %b run %b cnt %0d expected 0 0 0", chipselect, running, tick_count); end
    reset_n = 1'b1;
    @(negedge clk);
    blog.delete();
    cmd_start = 1'b1; m = cyc;
    @(negedge clk); cmd_start = 1'b0;
    @(negedge clk);
    @(negedge clk); irq_set = 1'b1;
    @(negedge clk); irq_set = 1'b0;
    repeat (4) @(negedge clk);
    vec++;
    if (blog.size() != 5) begin errs++; $display("FAIL rm_len: got %0d writes expected 5", blog.size()); end
    else begin
      vec++; if (blog[3].c !== m + 4 || blog[3].a !== 3'd1 || blog[3].d !== 16'h0007)
        begin errs++; $display("FAIL rm_ctrl: got cyc %0d (%0d,%h) expected 4 (1,0007)", blog[3].c - m, blog[3].a, blog[3].d); end
      vec++; if (blog[4].c !== m + 6 || blog[4].a !== 3'd0 || !blog[4].wr)
        begin errs++; $display("FAIL rm_clr: got cyc %0d a %0d expected 6 0", blog[4].c - m, blog[4].a); end
    end
    vec++; if (running !== 1'b1 || tick_count !== 16'd1) begin errs++; $display("FAIL rm_after: got run %b cnt %0d expected 1 1", running, tick_count); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_continuous();
    test_start_stop();
    test_oneshot();
    test_snap();
    test_period_bounds();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
